// File: rtl/fp_execute_stage5.sv
// Final FP pipeline stage: normalize, round and pack per lane, then register results for writeback.
// Optional per-thread sticky exception flags are built when FP_EXCEPTION_FLAGS_EN is defined.
module fp_execute_stage5 #(
    parameter int NUM_LANES    = 16,
    parameter int NUM_THREADS  = 4,
    parameter int INSTR_W      = 32,
    parameter int SUBCYCLE_W   = 4,
    parameter int THREAD_IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fx4_instruction_valid,
    input  logic [INSTR_W-1:0]        fx4_instruction,
    input  logic [NUM_LANES-1:0]      fx4_mask_value,
    input  logic [THREAD_IDX_W-1:0]   fx4_thread_idx,
    input  logic [SUBCYCLE_W-1:0]     fx4_subcycle,
    input  logic [NUM_LANES-1:0]      fx4_result_is_inf,
    input  logic [NUM_LANES-1:0]      fx4_result_is_nan,
    input  logic [NUM_LANES*8-1:0]    fx4_add_exponent,
    input  logic [NUM_LANES*32-1:0]   fx4_add_significand,
    input  logic [NUM_LANES-1:0]      fx4_add_result_sign,
    input  logic [NUM_LANES-1:0]      fx4_logical_subtract,
    input  logic [NUM_LANES*6-1:0]    fx4_norm_shift,
    input  logic [NUM_LANES*64-1:0]   fx4_significand_product,
    input  logic [NUM_LANES*8-1:0]    fx4_mul_exponent,
    input  logic [NUM_LANES-1:0]      fx4_mul_sign,
`ifdef FP_EXCEPTION_FLAGS_EN
    input  logic [NUM_THREADS-1:0]    fp_flags_clear,
    output logic [NUM_THREADS*4-1:0]  fx5_fp_flags,
`endif
    output logic                      fx5_instruction_valid,
    output logic [INSTR_W-1:0]        fx5_instruction,
    output logic [NUM_LANES-1:0]      fx5_mask_value,
    output logic [THREAD_IDX_W-1:0]   fx5_thread_idx,
    output logic [SUBCYCLE_W-1:0]     fx5_subcycle,
    output logic [NUM_LANES*32-1:0]   fx5_result
);

    localparam logic [5:0] OP_FADD = 6'h20;
    localparam logic [5:0] OP_FSUB = 6'h21;
    localparam logic [5:0] OP_FMUL = 6'h22;
    localparam logic [5:0] OP_FTOI = 6'h1B;

    logic [5:0] alu_op;
    logic       is_add;
    logic       is_fmul;
    logic       is_ftoi;

    assign alu_op  = fx4_instruction[5:0];
    assign is_add  = (alu_op == OP_FADD) || (alu_op == OP_FSUB);
    assign is_fmul = (alu_op == OP_FMUL);
    assign is_ftoi = (alu_op == OP_FTOI);

    logic [NUM_LANES*32-1:0] result_d;
`ifdef FP_EXCEPTION_FLAGS_EN
    logic [NUM_LANES*4-1:0]  lane_evt;
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [31:0]       sig;
        logic [31:0]       shifted;
        logic [31:0]       res;
        logic [5:0]        nshift;
        logic [47:0]       prod;
        logic [15:0]       unused_prod_hi;
        logic signed [9:0] add_exp;
        logic signed [9:0] mul_exp;
        logic signed [9:0] exp_sel;
        logic signed [9:0] exp_r;
        logic [22:0]       mant;
        logic [23:0]       mant_inc;
        logic              grd;
        logic              stk;
        logic              sign;
        logic              round_up;
        logic              ovf;
        logic              unf;
        logic              zero;
        logic              pack;
        logic              nan;
        logic              inf;

        assign sig            = fx4_add_significand[l*32 +: 32];
        assign nshift         = fx4_norm_shift[l*6 +: 6];
        assign prod           = fx4_significand_product[l*64 +: 48];
        assign unused_prod_hi = fx4_significand_product[l*64+48 +: 16];
        assign nan            = fx4_result_is_nan[l];
        assign inf            = fx4_result_is_inf[l];

        always_comb begin
            shifted = sig << nshift;
            add_exp = $signed({2'b00, fx4_add_exponent[l*8 +: 8]}) + 10'sd8
                      - $signed({4'b0000, nshift});
            mul_exp = $signed({2'b00, fx4_mul_exponent[l*8 +: 8]})
                      + $signed({9'd0, prod[47]});
            if (is_fmul) begin
                sign    = fx4_mul_sign[l];
                exp_sel = mul_exp;
                if (prod[47]) begin
                    {mant, grd} = prod[46:23];
                    stk         = |prod[22:0];
                end else begin
                    {mant, grd} = prod[45:22];
                    stk         = |prod[21:0];
                end
            end else begin
                sign    = fx4_add_result_sign[l];
                exp_sel = add_exp;
                mant    = shifted[30:8];
                grd     = shifted[7];
                stk     = |shifted[6:0];
            end

            // Round to nearest even; a carry out leaves the low mantissa bits at zero.
            round_up = grd & (stk | mant[0]);
            mant_inc = {1'b0, mant} + {23'd0, round_up};
            exp_r    = exp_sel + $signed({9'd0, mant_inc[23]});
            ovf      = (exp_r >= 10'sd255);
            unf      = (exp_r <= 10'sd0);
            zero     = (nshift == 6'd32);
            pack     = !nan && !inf && !is_ftoi && (is_fmul || (is_add && !zero));

            res = sig;
            if (nan) begin
                res = 32'h7FFF_FFFF;
            end else if (inf) begin
                res = {sign, 8'hFF, 23'd0};
            end else if (is_ftoi) begin
                res = fx4_add_result_sign[l] ? -shifted : shifted;
            end else if (pack) begin
                if (ovf) begin
                    res = {sign, 8'hFF, 23'd0};
                end else if (unf) begin
                    res = {sign, 31'd0};
                end else begin
                    res = {sign, exp_r[7:0], mant_inc[22:0]};
                end
            end else if (is_add) begin
                res = fx4_logical_subtract[l] ? 32'd0 : {fx4_add_result_sign[l], 31'd0};
            end
        end

        assign result_d[l*32 +: 32] = res;
`ifdef FP_EXCEPTION_FLAGS_EN
        assign lane_evt[l*4 +: 4] = {nan, pack & ovf, pack & unf, pack & (grd | stk | ovf | unf)};
`endif
    end

`ifdef FP_EXCEPTION_FLAGS_EN
    logic [NUM_THREADS*4-1:0] flags_q;
    logic [NUM_THREADS*4-1:0] flags_d;
    logic [3:0]               evt_any;

    // Clear wins over the old value, but a same-cycle event is still recorded.
    always_comb begin
        evt_any = 4'd0;
        flags_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (fx4_mask_value[l]) begin
                evt_any = evt_any | lane_evt[l*4 +: 4];
            end
        end
        if (!fx4_instruction_valid) begin
            evt_any = 4'd0;
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            flags_d[t*4 +: 4] = fp_flags_clear[t] ? 4'd0 : flags_q[t*4 +: 4];
            if (fx4_thread_idx == THREAD_IDX_W'(t)) begin
                flags_d[t*4 +: 4] = flags_d[t*4 +: 4] | evt_any;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign fx5_fp_flags = flags_q;
`endif

    logic                    valid_q;
    logic [INSTR_W-1:0]      instr_q;
    logic [NUM_LANES-1:0]    mask_q;
    logic [THREAD_IDX_W-1:0] thread_q;
    logic [SUBCYCLE_W-1:0]   subcycle_q;
    logic [NUM_LANES*32-1:0] result_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            mask_q     <= '0;
            thread_q   <= '0;
            subcycle_q <= '0;
            result_q   <= '0;
        end else begin
            valid_q    <= fx4_instruction_valid;
            instr_q    <= fx4_instruction;
            mask_q     <= fx4_mask_value;
            thread_q   <= fx4_thread_idx;
            subcycle_q <= fx4_subcycle;
            result_q   <= result_d;
        end
    end

    assign fx5_instruction_valid = valid_q;
    assign fx5_instruction       = instr_q;
    assign fx5_mask_value        = mask_q;
    assign fx5_thread_idx        = thread_q;
    assign fx5_subcycle          = subcycle_q;
    assign fx5_result            = result_q;

endmodule

// File: tb/tb_fp_execute_stage5.sv
// Directed-vector bench for fp_execute_stage5; flag scenarios build only with FP_EXCEPTION_FLAGS_EN.
module tb_fp_execute_stage5;

    localparam int NL = 16;
    localparam int NT = 4;
    localparam logic [5:0] OP_FADD = 6'h20;
    localparam logic [5:0] OP_FSUB = 6'h21;
    localparam logic [5:0] OP_FMUL = 6'h22;
    localparam logic [5:0] OP_FTOI = 6'h1B;

    logic            clk;
    logic            reset_n;
    logic            fx4_instruction_valid;
    logic [31:0]     fx4_instruction;
    logic [NL-1:0]   fx4_mask_value;
    logic [1:0]      fx4_thread_idx;
    logic [3:0]      fx4_subcycle;
    logic [NL-1:0]   fx4_result_is_inf;
    logic [NL-1:0]   fx4_result_is_nan;
    logic [NL*8-1:0] fx4_add_exponent;
    logic [NL*32-1:0] fx4_add_significand;
    logic [NL-1:0]   fx4_add_result_sign;
    logic [NL-1:0]   fx4_logical_subtract;
    logic [NL*6-1:0] fx4_norm_shift;
    logic [NL*64-1:0] fx4_significand_product;
    logic [NL*8-1:0] fx4_mul_exponent;
    logic [NL-1:0]   fx4_mul_sign;
    logic            fx5_instruction_valid;
    logic [31:0]     fx5_instruction;
    logic [NL-1:0]   fx5_mask_value;
    logic [1:0]      fx5_thread_idx;
    logic [3:0]      fx5_subcycle;
    logic [NL*32-1:0] fx5_result;
`ifdef FP_EXCEPTION_FLAGS_EN
    logic [NT-1:0]   fp_flags_clear;
    logic [NT*4-1:0] fx5_fp_flags;
`endif

    int errors = 0;
    int checks = 0;

    fp_execute_stage5 #(.NUM_LANES(NL), .NUM_THREADS(NT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .fx4_instruction_valid   (fx4_instruction_valid),
        .fx4_instruction         (fx4_instruction),
        .fx4_mask_value          (fx4_mask_value),
        .fx4_thread_idx          (fx4_thread_idx),
        .fx4_subcycle            (fx4_subcycle),
        .fx4_result_is_inf       (fx4_result_is_inf),
        .fx4_result_is_nan       (fx4_result_is_nan),
        .fx4_add_exponent        (fx4_add_exponent),
        .fx4_add_significand     (fx4_add_significand),
        .fx4_add_result_sign     (fx4_add_result_sign),
        .fx4_logical_subtract    (fx4_logical_subtract),
        .fx4_norm_shift          (fx4_norm_shift),
        .fx4_significand_product (fx4_significand_product),
        .fx4_mul_exponent        (fx4_mul_exponent),
        .fx4_mul_sign            (fx4_mul_sign),
`ifdef FP_EXCEPTION_FLAGS_EN
        .fp_flags_clear          (fp_flags_clear),
        .fx5_fp_flags            (fx5_fp_flags),
`endif
        .fx5_instruction_valid   (fx5_instruction_valid),
        .fx5_instruction         (fx5_instruction),
        .fx5_mask_value          (fx5_mask_value),
        .fx5_thread_idx          (fx5_thread_idx),
        .fx5_subcycle            (fx5_subcycle),
        .fx5_result              (fx5_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_res(input int l);
        return fx5_result[l*32 +: 32];
    endfunction

    task automatic clear_inputs();
        fx4_instruction_valid   = 1'b0;
        fx4_instruction         = {26'd0, OP_FADD};
        fx4_mask_value          = '1;
        fx4_thread_idx          = 2'd0;
        fx4_subcycle            = 4'd0;
        fx4_result_is_inf       = '0;
        fx4_result_is_nan       = '0;
        fx4_add_exponent        = '0;
        fx4_add_significand     = '0;
        fx4_add_result_sign     = '0;
        fx4_logical_subtract    = '0;
        fx4_significand_product = '0;
        fx4_mul_exponent        = '0;
        fx4_mul_sign            = '0;
        for (int l = 0; l < NL; l++) fx4_norm_shift[l*6 +: 6] = 6'd32;
`ifdef FP_EXCEPTION_FLAGS_EN
        fp_flags_clear = '0;
`endif
    endtask

    task automatic set_op(input logic [5:0] op);
        fx4_instruction = {26'h15A_5A5, op};
    endtask

    task automatic set_add(input int l, input logic [7:0] e, input logic [31:0] s,
                           input logic [5:0] sh, input logic sg, input logic ls);
        fx4_add_exponent[l*8 +: 8]     = e;
        fx4_add_significand[l*32 +: 32] = s;
        fx4_norm_shift[l*6 +: 6]       = sh;
        fx4_add_result_sign[l]         = sg;
        fx4_logical_subtract[l]        = ls;
    endtask

    task automatic set_mul(input int l, input logic [47:0] p, input logic [7:0] e, input logic sg);
        fx4_significand_product[l*64 +: 64] = {16'd0, p};
        fx4_mul_exponent[l*8 +: 8]          = e;
        fx4_mul_sign[l]                     = sg;
    endtask

    task automatic test_reset();
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FADD);
        set_add(0, 8'd127, 32'h0100_0000, 6'd7, 1'b0, 1'b0);
        fx4_thread_idx = 2'd3;
        fx4_subcycle   = 4'd5;
        fx4_mask_value = 16'hA5C3;
        reset_n = 1'b0;
        step();
        checks++;
        if (fx5_instruction_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", fx5_instruction_valid);
        end
        checks++;
        if (fx5_result !== '0) begin
            errors++; $display("FAIL reset_result: lane0 got %h want 0", lane_res(0));
        end
        checks++;
        if ({fx5_instruction, fx5_thread_idx, fx5_subcycle, fx5_mask_value} !== '0) begin
            errors++; $display("FAIL reset_passthru: instr %h thr %0d sub %0d mask %h want 0",
                               fx5_instruction, fx5_thread_idx, fx5_subcycle, fx5_mask_value);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (fx5_instruction_valid !== 1'b1) begin
            errors++; $display("FAIL reset_release_valid: got %b want 1", fx5_instruction_valid);
        end
        checks++;
        if (lane_res(0) !== 32'h4000_0000) begin
            errors++; $display("FAIL reset_release_result: got %h want 40000000", lane_res(0));
        end
        checks++;
        if (fx5_instruction !== {26'h15A_5A5, OP_FADD} || fx5_thread_idx !== 2'd3 ||
            fx5_subcycle !== 4'd5 || fx5_mask_value !== 16'hA5C3) begin
            errors++; $display("FAIL passthru: instr %h thr %0d sub %0d mask %h", fx5_instruction,
                               fx5_thread_idx, fx5_subcycle, fx5_mask_value);
        end
    endtask

    task automatic test_fadd();
        logic [31:0] expv [6];
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FADD);
        set_add(0, 8'd127, 32'h0100_0000, 6'd7, 1'b0, 1'b0); expv[0] = 32'h4000_0000;
        set_add(1, 8'd100, 32'hFFFF_FF80, 6'd0, 1'b0, 1'b0); expv[1] = 32'h3680_0000;
        set_add(2, 8'd126, 32'h0100_0000, 6'd7, 1'b1, 1'b0); expv[2] = 32'hBF80_0000;
        set_add(3, 8'd119, 32'h8000_0180, 6'd0, 1'b0, 1'b0); expv[3] = 32'h3F80_0002;
        set_add(4, 8'd119, 32'h8000_00C0, 6'd0, 1'b0, 1'b0); expv[4] = 32'h3F80_0001;
        set_add(5, 8'd119, 32'h8000_0080, 6'd0, 1'b0, 1'b0); expv[5] = 32'h3F80_0000;
        step();
        for (int l = 0; l < 6; l++) begin
            checks++;
            if (lane_res(l) !== expv[l]) begin
                errors++; $display("FAIL fadd lane%0d: got %h want %h", l, lane_res(l), expv[l]);
            end
        end
    endtask

    task automatic test_fmul();
        logic [31:0] expv [4];
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FMUL);
        set_mul(0, 48'h9000_0000_0000, 8'd127, 1'b0); expv[0] = 32'h4010_0000;
        set_mul(1, 48'h4000_0040_0000, 8'd127, 1'b0); expv[1] = 32'h3F80_0000;
        set_mul(2, 48'h4000_00C0_0000, 8'd127, 1'b0); expv[2] = 32'h3F80_0002;
        set_mul(3, 48'h8000_0000_0000, 8'd127, 1'b1); expv[3] = 32'hC000_0000;
        step();
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane_res(l) !== expv[l]) begin
                errors++; $display("FAIL fmul lane%0d: got %h want %h", l, lane_res(l), expv[l]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] expv [6];
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FMUL);
        set_mul(0, 48'h8000_0000_0000, 8'd254, 1'b0); expv[0] = 32'h7F80_0000;
        set_mul(2, 48'h8000_0000_0000, 8'd253, 1'b0); expv[2] = 32'h7F00_0000;
        set_mul(5, 48'h7FFF_FFC0_0000, 8'd254, 1'b0); expv[5] = 32'h7F80_0000;
        step();
        for (int l = 0; l < 6; l += 1) begin
            if (l == 0 || l == 2 || l == 5) begin
                checks++;
                if (lane_res(l) !== expv[l]) begin
                    errors++; $display("FAIL bound_mul lane%0d: got %h want %h", l, lane_res(l), expv[l]);
                end
            end
        end
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FADD);
        set_add(1, 8'd0, 32'h0010_0000, 6'd11, 1'b0, 1'b0); expv[1] = 32'h0000_0000;
        set_add(3, 8'd0, 32'h0100_0000, 6'd7,  1'b0, 1'b0); expv[3] = 32'h0080_0000;
        set_add(4, 8'd0, 32'h0080_0000, 6'd8,  1'b1, 1'b0); expv[4] = 32'h8000_0000;
        fx4_add_significand[1*32 +: 32] = 32'h0010_0000;
        step();
        for (int l = 0; l < 6; l += 1) begin
            if (l == 1 || l == 3 || l == 4) begin
                checks++;
                if (lane_res(l) !== expv[l]) begin
                    errors++; $display("FAIL bound_add lane%0d: got %h want %h", l, lane_res(l), expv[l]);
                end
            end
        end
    endtask

    task automatic test_zero_override();
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FSUB);
        set_add(0, 8'd90, 32'h0, 6'd32, 1'b1, 1'b1);
        set_add(1, 8'd90, 32'h0, 6'd32, 1'b1, 1'b0);
        set_add(2, 8'd127, 32'h0100_0000, 6'd7, 1'b0, 1'b0);
        fx4_result_is_nan[2] = 1'b1;
        set_add(3, 8'd127, 32'h0100_0000, 6'd7, 1'b1, 1'b0);
        fx4_result_is_inf[3] = 1'b1;
        fx4_result_is_nan[4] = 1'b1;
        fx4_result_is_inf[4] = 1'b1;
        step();
        checks++;
        if (lane_res(0) !== 32'h0) begin
            errors++; $display("FAIL zero_sub: got %h want 00000000", lane_res(0));
        end
        checks++;
        if (lane_res(1) !== 32'h8000_0000) begin
            errors++; $display("FAIL zero_signed: got %h want 80000000", lane_res(1));
        end
        checks++;
        if (lane_res(2) !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL force_nan: got %h want 7fffffff", lane_res(2));
        end
        checks++;
        if (lane_res(3) !== 32'hFF80_0000) begin
            errors++; $display("FAIL force_inf: got %h want ff800000", lane_res(3));
        end
        checks++;
        if (lane_res(4) !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL nan_over_inf: got %h want 7fffffff", lane_res(4));
        end
    endtask

    task automatic test_ftoi_other();
        logic [31:0] expv [3];
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FTOI);
        set_add(0, 8'd0, 32'h5, 6'd0, 1'b1, 1'b0);          expv[0] = 32'hFFFF_FFFB;
        set_add(1, 8'd0, 32'h5, 6'd4, 1'b0, 1'b0);          expv[1] = 32'h0000_0050;
        set_add(2, 8'd0, 32'h8000_0000, 6'd0, 1'b0, 1'b0);  expv[2] = 32'h8000_0000;
        step();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (lane_res(l) !== expv[l]) begin
                errors++; $display("FAIL ftoi lane%0d: got %h want %h", l, lane_res(l), expv[l]);
            end
        end
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(6'h05);
        set_add(0, 8'd200, 32'h1234_5678, 6'd3, 1'b1, 1'b1);
        step();
        checks++;
        if (lane_res(0) !== 32'h1234_5678) begin
            errors++; $display("FAIL other_op: got %h want 12345678", lane_res(0));
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FMUL);
        fx4_thread_idx = 2'd1;
        set_mul(0, 48'h9000_0000_0000, 8'd127, 1'b0);
        step();
        checks++;
        if (lane_res(0) !== 32'h4010_0000 || fx5_thread_idx !== 2'd1) begin
            errors++; $display("FAIL b2b_first: got %h thr %0d want 40100000 thr 1", lane_res(0), fx5_thread_idx);
        end
        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FTOI);
        fx4_thread_idx = 2'd2;
        set_add(0, 8'd0, 32'h7, 6'd1, 1'b1, 1'b0);
        step();
        checks++;
        if (lane_res(0) !== 32'hFFFF_FFF2 || fx5_thread_idx !== 2'd2) begin
            errors++; $display("FAIL b2b_second: got %h thr %0d want fffffff2 thr 2", lane_res(0), fx5_thread_idx);
        end
        clear_inputs();
        step();
        checks++;
        if (fx5_instruction_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_valid: got %b want 0", fx5_instruction_valid);
        end
    endtask

`ifdef FP_EXCEPTION_FLAGS_EN
    task automatic test_flags();
        clear_inputs();
        fp_flags_clear = '1;
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0000) begin
            errors++; $display("FAIL flags_clear_all: got %h want 0000", fx5_fp_flags);
        end

        clear_inputs();
        fx4_instruction_valid = 1'b1;
        set_op(OP_FMUL);
        fx4_thread_idx = 2'd2;
        fx4_mask_value = 16'h0008;
        set_mul(3, 48'h8000_0000_0000, 8'd254, 1'b0);
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0500) begin
            errors++; $display("FAIL flags_overflow: got %h want 0500", fx5_fp_flags);
        end

        clear_inputs();
        fx4_instruction_valid = 1'b1;
        fx4_thread_idx = 2'd1;
        fx4_mask_value = 16'hFFFE;
        fx4_result_is_nan[0] = 1'b1;
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0500) begin
            errors++; $display("FAIL flags_masked_off: got %h want 0500", fx5_fp_flags);
        end

        clear_inputs();
        fx4_thread_idx = 2'd1;
        fx4_result_is_nan[0] = 1'b1;
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0500) begin
            errors++; $display("FAIL flags_invalid_instr: got %h want 0500", fx5_fp_flags);
        end

        clear_inputs();
        fx4_instruction_valid = 1'b1;
        fx4_thread_idx = 2'd0;
        set_add(1, 8'd0, 32'h0010_0000, 6'd11, 1'b0, 1'b0);
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0503) begin
            errors++; $display("FAIL flags_underflow: got %h want 0503", fx5_fp_flags);
        end

        clear_inputs();
        fx4_instruction_valid = 1'b1;
        fx4_thread_idx = 2'd2;
        fp_flags_clear = 4'b0100;
        fx4_result_is_nan[0] = 1'b1;
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0803) begin
            errors++; $display("FAIL flags_clear_and_set: got %h want 0803", fx5_fp_flags);
        end

        clear_inputs();
        fp_flags_clear = 4'b0001;
        step();
        checks++;
        if (fx5_fp_flags !== 16'h0800) begin
            errors++; $display("FAIL flags_clear_one: got %h want 0800", fx5_fp_flags);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        test_reset();
        test_fadd();
        test_fmul();
        test_boundaries();
        test_zero_override();
        test_ftoi_other();
        test_back_to_back();
`ifdef FP_EXCEPTION_FLAGS_EN
        test_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
